// File: rtl/nf10_rx_pkt_tagger.sv
// Store-and-forward RX tagger: buffers whole packets, drops any that do not fit,
// and re-emits them with length/src/dst metadata in tuser on the first beat.
// Ports: axi_aclk/axi_reset (sync, active-high); s_axis_* from the 10G MAC (never
// back-pressured); m_axis_* tagged packets out; drop_count (saturating) and
// pkt_count (wrapping) status counters.
module nf10_rx_pkt_tagger #(
  parameter int C_AXIS_DATA_WIDTH  = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int C_DATA_DEPTH       = 64,
  parameter int C_LEN_DEPTH        = 16,
  parameter logic [7:0] C_SRC_PORT = 8'h01,
  parameter logic [7:0] C_DST_PORT = 8'h00
) (
  input  logic                            axi_aclk,
  input  logic                            axi_reset,
  input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic                            s_axis_tlast,
  output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
  output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            m_axis_tlast,
  output logic [31:0]                     drop_count,
  output logic [31:0]                     pkt_count
);

  localparam int SW  = C_AXIS_DATA_WIDTH / 8;
  localparam int AW  = $clog2(C_DATA_DEPTH);
  localparam int PW  = AW + 1;
  localparam int LAW = $clog2(C_LEN_DEPTH);
  localparam int LPW = LAW + 1;
  localparam int MW  = C_AXIS_DATA_WIDTH + SW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_DROP
  } wr_state_t;

  function automatic logic [15:0] popcnt(
    input logic [SW-1:0] v
  );
    logic [15:0] c;
    c = '0;
    for (int i = 0; i < SW; i++)
      c = c + 16'(v[i]);
    return c;
  endfunction

  logic [MW-1:0] dmem [C_DATA_DEPTH];
  logic [15:0]   lmem [C_LEN_DEPTH];

  wr_state_t      st;
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  wr_commit;
  logic [PW-1:0]  pkt_start;
  logic [PW-1:0]  rd_ptr;
  logic [LPW-1:0] lwr_ptr;
  logic [LPW-1:0] lrd_ptr;
  logic [15:0]    len;
  logic           in_pkt;
  logic           sop;

  logic           accept;
  logic           dfull;
  logic           lfull;
  logic           live;
  logic           ovf;
  logic           we;
  logic           commit;
  logic [15:0]    len_sum;
  logic           avail;
  logic           out_fire;
  logic           eop;
  logic           load;
  logic [LAW-1:0] len_idx;
  logic [MW-1:0]  rd_word;
  logic           unused;

  assign unused = ^s_axis_tuser;

  assign s_axis_tready = !axi_reset;

  assign accept  = s_axis_tvalid && s_axis_tready;
  assign dfull   = (wr_ptr - rd_ptr) == PW'(C_DATA_DEPTH);
  assign lfull   = (lwr_ptr - lrd_ptr) == LPW'(C_LEN_DEPTH);
  assign live    = accept && (st != S_DROP);
  assign ovf     = live && (dfull || (s_axis_tlast && lfull));
  assign we      = live && !ovf;
  assign commit  = we && s_axis_tlast;
  assign len_sum = ((st == S_WRITE) ? len : 16'd0)
                 + popcnt(s_axis_tstrb);

  assign avail    = rd_ptr != wr_commit;
  assign out_fire = m_axis_tvalid && m_axis_tready;
  assign eop      = out_fire && m_axis_tlast;
  assign load     = avail && (!m_axis_tvalid || m_axis_tready);
  assign rd_word  = dmem[rd_ptr[AW-1:0]];
  // A first beat loaded while the previous last beat leaves the
  // output register must see the length entry behind the one popped now.
  assign len_idx  = lrd_ptr[LAW-1:0]
                  + LAW'(m_axis_tvalid && m_axis_tlast);

  // Tracks MAC framing even through reset, so a stream resumed
  // mid-packet is discarded up to its tlast.
  always_ff @(posedge axi_aclk) begin
    if (s_axis_tvalid)
      in_pkt <= !s_axis_tlast;
  end

  always_ff @(posedge axi_aclk) begin
    if (we)
      dmem[wr_ptr[AW-1:0]] <= {s_axis_tlast, s_axis_tstrb, s_axis_tdata};
    if (commit)
      lmem[lwr_ptr[LAW-1:0]] <= len_sum;
  end

  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      st         <= (s_axis_tvalid ? !s_axis_tlast : in_pkt)
                  ? S_DROP : S_IDLE;
      wr_ptr     <= '0;
      wr_commit  <= '0;
      pkt_start  <= '0;
      lwr_ptr    <= '0;
      len        <= '0;
      drop_count <= '0;
    end else if (ovf) begin
      if (st == S_WRITE)
        wr_ptr <= pkt_start;
      if (drop_count != 32'hFFFF_FFFF)
        drop_count <= drop_count + 32'd1;
      st <= s_axis_tlast ? S_IDLE : S_DROP;
    end else if (we) begin
      wr_ptr <= wr_ptr + PW'(1);
      len    <= len_sum;
      if (st == S_IDLE)
        pkt_start <= wr_ptr;
      if (s_axis_tlast) begin
        lwr_ptr   <= lwr_ptr + LPW'(1);
        wr_commit <= wr_ptr + PW'(1);
        st        <= S_IDLE;
      end else begin
        st <= S_WRITE;
      end
    end else if (accept && s_axis_tlast) begin
      st <= S_IDLE;
    end
  end

  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      rd_ptr        <= '0;
      lrd_ptr       <= '0;
      sop           <= 1'b1;
      pkt_count     <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tstrb  <= '0;
      m_axis_tuser  <= '0;
    end else begin
      if (eop) begin
        lrd_ptr   <= lrd_ptr + LPW'(1);
        pkt_count <= pkt_count + 32'd1;
      end
      if (load) begin
        m_axis_tvalid <= 1'b1;
        {m_axis_tlast, m_axis_tstrb, m_axis_tdata} <= rd_word;
        m_axis_tuser  <= sop
          ? {{(C_AXIS_TUSER_WIDTH-32){1'b0}},
             C_DST_PORT, C_SRC_PORT, lmem[len_idx]}
          : '0;
        sop    <= rd_word[MW-1];
        rd_ptr <= rd_ptr + PW'(1);
      end else if (out_fire) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_nf10_rx_pkt_tagger.sv
// Scoreboard bench for nf10_rx_pkt_tagger.
// Expected beats are queued at drive time and checked at the output handshake.
module tb_nf10_rx_pkt_tagger;

  logic         clk;
  logic         axi_reset;
  logic [255:0] s_tdata;
  logic [31:0]  s_tstrb;
  logic [127:0] s_tuser;
  logic         s_tvalid;
  logic         s_tready;
  logic         s_tlast;
  logic [255:0] m_tdata;
  logic [31:0]  m_tstrb;
  logic [127:0] m_tuser;
  logic         m_tvalid;
  logic         m_tready;
  logic         m_tlast;
  logic [31:0]  drop_count;
  logic [31:0]  pkt_count;

  nf10_rx_pkt_tagger dut (
    .axi_aclk      (clk),
    .axi_reset     (axi_reset),
    .s_axis_tdata  (s_tdata),
    .s_axis_tstrb  (s_tstrb),
    .s_axis_tuser  (s_tuser),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tlast  (s_tlast),
    .m_axis_tdata  (m_tdata),
    .m_axis_tstrb  (m_tstrb),
    .m_axis_tuser  (m_tuser),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tlast  (m_tlast),
    .drop_count    (drop_count),
    .pkt_count     (pkt_count)
  );

  typedef struct {
    logic [255:0] d;
    logic [31:0]  s;
    logic         l;
    logic [127:0] u;
  } beat_t;

  beat_t sbq[$];
  int n_cmp = 0;
  int n_err = 0;
  int exp_pkt = 0;
  int exp_drop = 0;
  int rdy_mode = 1;
  logic         prev_stall = 1'b0;
  logic [255:0] prev_d;
  logic [127:0] prev_u;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] got,
                     input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int q_pkts();
    int c = 0;
    foreach (sbq[i]) if (sbq[i].l) c++;
    return c;
  endfunction

  initial begin
    m_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: m_tready = 1'b0;
        1: m_tready = 1'b1;
        default: m_tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (axi_reset) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("hold_valid", 256'(m_tvalid), 256'd1);
          chk("hold_data", m_tdata, prev_d);
          chk("hold_user", 256'(m_tuser), 256'(prev_u));
        end
        if (m_tvalid && m_tready) begin
          if (sbq.size() == 0) begin
            chk("extra_beat", 256'd1, 256'd0);
          end else begin
            beat_t b;
            b = sbq.pop_front();
            chk("tdata", m_tdata, b.d);
            chk("tstrb", 256'(m_tstrb), 256'(b.s));
            chk("tlast", 256'(m_tlast), 256'(b.l));
            chk("tuser", 256'(m_tuser), 256'(b.u));
            if (b.l) exp_pkt++;
          end
        end
        prev_stall = m_tvalid && !m_tready;
        prev_d = m_tdata;
        prev_u = m_tuser;
      end
    end
  end

  function automatic logic [31:0] mask(input int nb);
    logic [31:0] m = '0;
    for (int i = 0; i < nb; i++) m[i] = 1'b1;
    return m;
  endfunction

  task automatic send_pkt(input int nbytes, input bit keep);
    int n = (nbytes + 31) / 32;
    for (int i = 0; i < n; i++) begin
      beat_t b;
      @(posedge clk);
      #1;
      b.d = {8{$urandom}};
      b.s = mask((i == n - 1) ? nbytes - 32 * i : 32);
      b.l = (i == n - 1);
      b.u = (i == 0) ? {96'd0, 8'h00, 8'h01, 16'(nbytes)} : 128'd0;
      s_tdata  = b.d;
      s_tstrb  = b.s;
      s_tlast  = b.l;
      s_tuser  = 128'(~b.d);
      s_tvalid = 1'b1;
      if (keep) sbq.push_back(b);
    end
  endtask

  task automatic idle_in();
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (sbq.size() != 0 && t < 20000) begin
      @(posedge clk);
      t++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("drain", 256'(sbq.size()), 256'd0);
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, "_pkt"}, 256'(pkt_count), 256'(exp_pkt));
    chk({tag, "_drop"}, 256'(drop_count), 256'(exp_drop));
  endtask

  initial begin
    axi_reset = 1'b1;
    s_tvalid  = 1'b0;
    s_tlast   = 1'b0;
    s_tdata   = '0;
    s_tstrb   = '0;
    s_tuser   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tready", 256'(s_tready), 256'd0);
    chk("rst_valid", 256'(m_tvalid), 256'd0);
    axi_reset = 1'b0;
    @(posedge clk);
    #1;
    chk("tready", 256'(s_tready), 256'd1);
    chk("rst_tdata", m_tdata, 256'd0);
    chk("rst_tuser", 256'(m_tuser), 256'd0);
    chk("rst_tstrb", 256'(m_tstrb), 256'd0);
    chk("rst_tlast", 256'(m_tlast), 256'd0);
    chk_counts("rst");

    send_pkt(64, 1);
    idle_in();
    drain();
    chk_counts("p64");

    send_pkt(65, 1);
    idle_in();
    drain();
    chk_counts("p65");

    rdy_mode = 0;
    send_pkt(960, 1);
    send_pkt(1280, 0);
    idle_in();
    repeat (5) @(posedge clk);
    #1;
    exp_drop++;
    chk("a_held", 256'(m_tvalid), 256'd1);
    chk("a_user", 256'(m_tuser), 256'({96'd0, 32'h0001_03C0}));
    chk_counts("ovf");
    rdy_mode = 1;
    drain();
    send_pkt(320, 1);
    idle_in();
    drain();
    chk_counts("pkt_c");

    rdy_mode = 0;
    for (int k = 0; k < 16; k++) send_pkt(2 * k + 1, 1);
    send_pkt(7, 0);
    idle_in();
    repeat (5) @(posedge clk);
    #1;
    exp_drop++;
    chk_counts("lfull");
    rdy_mode = 1;
    drain();
    chk_counts("lfull_out");

    rdy_mode = 2;
    for (int p = 0; p < 200; p++) begin
      int nb = $urandom_range(60, 1518);
      int n = (nb + 31) / 32;
      if (sbq.size() + n > 62 || q_pkts() >= 15) begin
        int t = 0;
        idle_in();
        while ((sbq.size() + n > 62 || q_pkts() >= 15) && t < 20000) begin
          @(posedge clk);
          t++;
        end
      end
      send_pkt(nb, 1);
    end
    idle_in();
    drain();
    chk_counts("rand");

    rdy_mode = 1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      s_tdata   = {8{$urandom}};
      s_tstrb   = 32'hFFFF_FFFF;
      s_tlast   = (i == 4);
      s_tvalid  = 1'b1;
      axi_reset = (i == 2);
    end
    idle_in();
    exp_pkt  = 0;
    exp_drop = 0;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_mid_valid", 256'(m_tvalid), 256'd0);
    chk_counts("rst_mid");
    send_pkt(100, 1);
    idle_in();
    drain();
    chk_counts("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/nf10_rx_pkt_tagger.md
Name: nf10_rx_pkt_tagger

Overview:
- Store-and-forward stage directly downstream of the 10G interface receive master port (m_axis, 256-bit data, 128-bit tuser).
- Buffers each received packet completely and counts its bytes.
- Re-emits the packet with NetFPGA metadata in tuser on the first beat: byte length, source port, destination port.
- The MAC side cannot be back-pressured. Packets that do not fit are dropped whole and counted, so no truncated packet ever reaches the pipeline.

Parameters:
- C_AXIS_DATA_WIDTH, 256, tdata width; tstrb width is C_AXIS_DATA_WIDTH/8.
- C_AXIS_TUSER_WIDTH, 128, tuser width.
- C_DATA_DEPTH, 64, data FIFO depth in beats; power of 2, ≥ 4.
- C_LEN_DEPTH, 16, committed-packet length FIFO depth; power of 2.
- C_SRC_PORT, 8'h01, one-hot source port written to tuser[23:16].
- C_DST_PORT, 8'h00, default destination written to tuser[31:24].

Ports:
- axi_aclk, input, 1, single clock for the whole block.
- axi_reset, input, 1, reset; synchronous, active-high.
- s_axis_tdata, input, 256, receive data from the 10G interface.
- s_axis_tstrb, input, 32, byte enables; contiguous from bit 0.
- s_axis_tuser, input, 128, ignored.
- s_axis_tvalid, input, 1, beat valid.
- s_axis_tready, output, 1, always 1 after reset.
- s_axis_tlast, input, 1, last beat of the packet.
- m_axis_tdata, output, 256, tagged packet data.
- m_axis_tstrb, output, 32, byte enables.
- m_axis_tuser, output, 128, metadata; meaningful on the first beat only.
- m_axis_tvalid, output, 1, beat valid.
- m_axis_tready, input, 1, downstream ready.
- m_axis_tlast, output, 1, last beat of the packet.
- drop_count, output, 32, saturating count of dropped packets.
- pkt_count, output, 32, wrapping count of packets committed to the output.

Behaviour:
- Reset values: s_axis_tready=0 while axi_reset is high, then 1. All of the following are 0 and all FIFOs are empty:
  - m_axis_tvalid, m_axis_tlast, m_axis_tdata, m_axis_tstrb, m_axis_tuser
  - drop_count, pkt_count
- Write side state machine, states IDLE / WRITE / DROP:
  - IDLE: on an accepted beat, write it at wr_ptr and set len = popcount(tstrb). If tlast is set, commit immediately; otherwise go to WRITE. On the first beat, pkt_start = wr_ptr.
  - WRITE: each accepted beat is written and popcount(tstrb) is added to len (16-bit). On tlast, commit and go to IDLE.
  - Overflow: if the data FIFO is full when a beat arrives, rewind wr_ptr to pkt_start, increment drop_count and go to DROP.
  - DROP: discard beats; on tlast go to IDLE. drop_count increments once per dropped packet.
  - Commit: push len into the length FIFO and publish the committed write pointer (wr_commit = wr_ptr+1).
  - Length FIFO full at the tlast beat: drop the packet instead (rewind, drop_count++), return to IDLE.
  - A single-beat packet with the data FIFO full or the length FIFO full is dropped in the same cycle.
- Read side:
  - Reads only beats below wr_commit; uncommitted beats are never visible.
  - m_axis_tvalid rises at most 2 cycles after the tlast beat is accepted, provided the output is idle.
  - First beat: m_axis_tuser[15:0]=len, [23:16]=C_SRC_PORT, [31:24]=C_DST_PORT, all other bits 0. Subsequent beats: m_axis_tuser = 0.
  - On m_axis_tlast && m_axis_tready: pop the length FIFO and increment pkt_count.
  - Outputs hold stable while tvalid && !tready (AXI4-Stream rules).
  - Back-to-back packets stream with no idle cycle when the next packet is already committed.
- Simultaneous write commit and read pop in the same cycle: both take effect, FIFO occupancy is correct, no lost entry.
- Pointers are C_DATA_DEPTH-bit-log2+1 wide so that full and empty are distinguishable; they wrap naturally.
- Data FIFO full means (wr_ptr − rd_ptr) == C_DATA_DEPTH. Freed space is measured against rd_ptr, not wr_commit.
- Reset mid-operation:
  - All state returns to IDLE, FIFOs flush, counters clear.
  - A partially received packet is discarded silently; drop_count is not incremented.
  - If reset is released mid-packet on the input, the beats up to and including the next tlast are treated as DROP without counting.
- drop_count saturates at 32'hFFFFFFFF.

Test Plan:
- 64-byte packet, 2 beats with tstrb=32'hFFFFFFFF, m_axis_tready=1 → one 2-beat packet out, first tuser[31:0]=32'h0001_0040, data identical, pkt_count=1.
- 65-byte packet, 3 beats with last tstrb=32'h00000001 → tuser[15:0]=16'h0041, m_axis_tstrb on the last beat = 32'h1, m_axis_tlast only on beat 3.
- m_axis_tready=0, C_DATA_DEPTH=64, send 30-beat packet A then 40-beat packet B → A is held and valid, B is dropped, drop_count=1. After ready=1 only A is emitted; a later 10-beat packet C passes intact.
- Send 17 single-beat packets with tready=0 (C_LEN_DEPTH=16) → 16 are kept, the 17th is dropped, drop_count=1. Releasing ready yields 16 packets in order.
- Random ready toggling over 200 back-to-back packets of 60–1518 bytes → every packet emitted in order, byte-exact, lengths correct, no tvalid glitch while stalled.
- Assert axi_reset for 1 cycle in the middle of beat 3 of a 5-beat packet → the packet is never emitted, drop_count=0, and the next full packet passes correctly.
